sprite_renderer: RTL
====================

// Module: sprite_renderer
// PURPOSE
//  Downstream consumer of a synchronous sprite ROM (1-cycle registered read, 2-bit palette index).
//  Maps the VGA beam position (DrawX/DrawY) to a ROM address and aligns the ROM latency.
//  Resolves the palette index to 24-bit RGB with transparency, and steps animation frames on vsync.
//  Sits between the VGA controller / ROM pair and the colour mapper's layer mux.
// PARAMETERS
//  SPR_W      40         sprite width in pixels
//  SPR_H      78         sprite height in pixels
//  NUM_FRAMES 2          animation frames stored back-to-back in ROM (SPR_W*SPR_H*NUM_FRAMES = 6240)
//  FRAME_DIV  8          vsync periods per animation step (>=1)
//  ADDR_W     13         ROM address width
//  PAL1/2/3   24'hFFFFFF / 24'hC0C0C0 / 24'h404040   RGB for palette indices 1..3
// PORTS
//  Clk          in   1       pixel clock
//  Reset_n      in   1       asynchronous active-low reset
//  frame_clk    in   1       vsync-derived; rising edge marks frame start
//  DrawX        in   10      beam column 0..639
//  DrawY        in   10      beam row 0..479
//  SpriteX      in   10      requested sprite top-left X
//  SpriteY      in   10      requested sprite top-left Y
//  sprite_en    in   1       sprite visible (sampled with position)
//  rom_addr     out  ADDR_W  address to sprite ROM (registered)
//  rom_data     in   2       ROM output, valid 1 cycle after rom_addr
//  pixel_opaque out  1       sprite covers this pixel with non-transparent colour
//  pixel_rgb    out  24      sprite colour; 0 when pixel_opaque=0
// BEHAVIOUR
//  - Reset (async, Reset_n=0): all regs 0; rom_addr=0, pixel_opaque=0, pixel_rgb=0, frame idx=0,
//    div count=0, latched pos/en=0. Reset mid-frame: output transparent until the next full pipeline fill.
//  - frame_clk edge detect: 2-flop sync + previous-value reg; rise = sync & ~prev.
//  - On rise: latch SpriteX/SpriteY/sprite_en into pos regs (tear-free; used for whole frame).
//  - Hit (stage 1): 11-bit unsigned compare, no wrap: X_l<=DrawX<X_l+SPR_W and Y_l<=DrawY<Y_l+SPR_H,
//    and en_l=1. A sprite partially off-screen (X_l+SPR_W>640) clips; never wraps to column 0.
//  - Address (stage 1, registered): frame*SPR_W*SPR_H + (DrawY-Y_l)*SPR_W + (DrawX-X_l); on no-hit hold 0.
//  - Stage 2: ROM registers rom_data; hit delayed one cycle alongside (hit_d2).
//  - Stage 3 (registered outputs): pixel_opaque = hit_d2 & (rom_data!=0);
//    pixel_rgb = PALn for index n, 0 if index 0 or no hit.
//  - Latency: DrawX/DrawY at cycle N -> pixel_opaque/pixel_rgb valid at N+3 (fixed, every pixel).
//    The consumer delays its own DrawX/DrawY by 3.
//  - Animation FSM (per frame_clk rise): div count 0..FRAME_DIV-1. At FRAME_DIV-1 -> 0 and frame idx++.
//    Frame idx wraps NUM_FRAMES-1 -> 0. A frame change and a position latch on the same rise both
//    take effect for the new frame.
// CONFIGURATION
//  SPRITE_HFLIP_EN defined: extra input port hflip (1b, latched with position on frame_clk rise).
//    When latched 1, column term = SPR_W-1-(DrawX-X_l). Latency unchanged.
//  SPRITE_HFLIP_EN undefined: no hflip port; column term = DrawX-X_l.
// STRUCTURE
//  - sprite_pkg: SPR_W/SPR_H defaults, rgb_t (24b typedef), pal_idx_t (2b), SCREEN_W=640, SCREEN_H=480.
//  - Sub-module: sprite_anim_ctrl (frame_clk sync/edge detect, div counter, frame idx, position latch).
//  - Top holds the 3-stage pixel pipeline.
// TESTING
//  1. Reset_n=0 mid-line with DrawX sweeping -> pixel_opaque=0, pixel_rgb=0, rom_addr=0 throughout;
//     release -> first valid output 3 cycles later.
//  2. SpriteX=100, SpriteY=50 latched, frame0; DrawX=100, DrawY=50 -> rom_addr=0.
//     DrawX=139, DrawY=127 -> rom_addr=3119. ROM model data 1 -> pixel_rgb=FFFFFF at N+3.
//  3. rom_data=0 inside sprite -> pixel_opaque=0, rgb=0. DrawX=140 (just outside) -> no hit, rom_addr=0.
//  4. SpriteX=620 -> DrawX 620..639 hit; no hit at DrawX 0..19 (no wrap).
//  5. FRAME_DIV=8: 8 frame_clk rises -> frame idx 1, address at sprite origin = 3120.
//     16 rises -> wraps to 0.
//  6. Change SpriteX mid-frame -> hit region unchanged until next frame_clk rise.
//     With SPRITE_HFLIP_EN and hflip=1: DrawX=X_l -> column 39.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry defaults, palette colours and pixel types
package sprite_pkg;
  localparam int SPR_W_DEF      = 40;
  localparam int SPR_H_DEF      = 78;
  localparam int NUM_FRAMES_DEF = 2;
  localparam int FRAME_DIV_DEF  = 8;
  localparam int ADDR_W_DEF     = 13;
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;

  typedef logic [23:0] rgb_t;
  typedef logic [1:0]  pal_idx_t;

  localparam rgb_t PAL1_DEF = 24'hFFFFFF;
  localparam rgb_t PAL2_DEF = 24'hC0C0C0;
  localparam rgb_t PAL3_DEF = 24'h404040;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sprite_renderer_if.sv
// rtl/sprite_renderer_if.sv - sprite ROM read port (registered address out, index data back)
interface sprite_renderer_if #(
  parameter int ADDR_W = 13
);
  import sprite_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  pal_idx_t          rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// rtl/sprite_anim_ctrl.sv - frame_clk edge detect, per-frame position latch, animation stepping
// Optional SPRITE_HFLIP_EN adds a horizontal flip bit latched with the position.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter  int NUM_FRAMES = NUM_FRAMES_DEF,
  parameter  int FRAME_DIV  = FRAME_DIV_DEF,
  localparam int FIDX_W     = idx_w(NUM_FRAMES),
  localparam int DIV_W      = idx_w(FRAME_DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_clk,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_en,
`ifdef SPRITE_HFLIP_EN
  input  logic              hflip,
  output logic              hflip_l,
`endif
  output logic [9:0]        x_l,
  output logic [9:0]        y_l,
  output logic              en_l,
  output logic [FIDX_W-1:0] frame_idx
);
  logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              en_q, en_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FIDX_W-1:0] frame_q, frame_d;
  logic              rise;
`ifdef SPRITE_HFLIP_EN
  logic              flip_q, flip_d;
`endif

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    x_d     = x_q;
    y_d     = y_q;
    en_d    = en_q;
    div_d   = div_q;
    frame_d = frame_q;
`ifdef SPRITE_HFLIP_EN
    flip_d  = flip_q;
`endif
    if (rise) begin
      // Position and frame step both land on the same rise so a frame never tears.
      x_d  = sprite_x;
      y_d  = sprite_y;
      en_d = sprite_en;
`ifdef SPRITE_HFLIP_EN
      flip_d = hflip;
`endif
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FIDX_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= 1'b0;
      div_q   <= '0;
      frame_q <= '0;
`ifdef SPRITE_HFLIP_EN
      flip_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      div_q   <= div_d;
      frame_q <= frame_d;
`ifdef SPRITE_HFLIP_EN
      flip_q  <= flip_d;
`endif
    end
  end

  assign x_l       = x_q;
  assign y_l       = y_q;
  assign en_l      = en_q;
  assign frame_idx = frame_q;
`ifdef SPRITE_HFLIP_EN
  assign hflip_l   = flip_q;
`endif
endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - 3-stage beam-to-RGB sprite pipeline around a 1-cycle sprite ROM
// Optional SPRITE_HFLIP_EN adds the hflip input and mirrored column addressing.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int   SPR_W      = SPR_W_DEF,
  parameter int   SPR_H      = SPR_H_DEF,
  parameter int   NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int   FRAME_DIV  = FRAME_DIV_DEF,
  parameter int   ADDR_W     = ADDR_W_DEF,
  parameter rgb_t PAL1       = PAL1_DEF,
  parameter rgb_t PAL2       = PAL2_DEF,
  parameter rgb_t PAL3       = PAL3_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [9:0]                SpriteX,
  input  logic [9:0]                SpriteY,
  input  logic                      sprite_en,
`ifdef SPRITE_HFLIP_EN
  input  logic                      hflip,
`endif
  sprite_renderer_if.master         rom_if,
  output logic                      pixel_opaque,
  output rgb_t                      pixel_rgb
);
  localparam int FIDX_W = idx_w(NUM_FRAMES);

  logic [9:0]        x_l, y_l;
  logic              en_l;
  logic [FIDX_W-1:0] frame_idx;
`ifdef SPRITE_HFLIP_EN
  logic              hflip_l;
`endif

  sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_anim (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .frame_clk (frame_clk),
    .sprite_x  (SpriteX),
    .sprite_y  (SpriteY),
    .sprite_en (sprite_en),
`ifdef SPRITE_HFLIP_EN
    .hflip     (hflip),
    .hflip_l   (hflip_l),
`endif
    .x_l       (x_l),
    .y_l       (y_l),
    .en_l      (en_l),
    .frame_idx (frame_idx)
  );

  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit_d1_q, hit_d1_d, hit_d2_q, hit_d2_d;
  logic              pixel_opaque_q, pixel_opaque_d;
  rgb_t              pixel_rgb_q, pixel_rgb_d;
  logic [10:0]       dx, dy, col;
  logic              hit;

  // Stage 1: 11-bit compares so a sprite hanging off the right edge clips instead of wrapping.
  always_comb begin
    dx  = {1'b0, DrawX} - {1'b0, x_l};
    dy  = {1'b0, DrawY} - {1'b0, y_l};
    hit = en_l
          && ({1'b0, DrawX} >= {1'b0, x_l}) && ({1'b0, DrawX} < ({1'b0, x_l} + 11'(SPR_W)))
          && ({1'b0, DrawY} >= {1'b0, y_l}) && ({1'b0, DrawY} < ({1'b0, y_l} + 11'(SPR_H)));
`ifdef SPRITE_HFLIP_EN
    col = hflip_l ? (11'(SPR_W - 1) - dx) : dx;
`else
    col = dx;
`endif
    rom_addr_d = '0;
    if (hit) begin
      rom_addr_d = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H)
                 + ADDR_W'(dy) * ADDR_W'(SPR_W)
                 + ADDR_W'(col);
    end
    hit_d1_d = hit;
  end

  // Stage 2 is the ROM register itself; the hit flag travels alongside it.
  always_comb begin
    hit_d2_d       = hit_d1_q;
    pixel_opaque_d = hit_d2_q && (rom_if.rom_data != 2'd0);
    pixel_rgb_d    = '0;
    if (hit_d2_q) begin
      unique case (rom_if.rom_data)
        2'd1:    pixel_rgb_d = PAL1;
        2'd2:    pixel_rgb_d = PAL2;
        2'd3:    pixel_rgb_d = PAL3;
        default: pixel_rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q     <= '0;
      hit_d1_q       <= 1'b0;
      hit_d2_q       <= 1'b0;
      pixel_opaque_q <= 1'b0;
      pixel_rgb_q    <= '0;
    end else begin
      rom_addr_q     <= rom_addr_d;
      hit_d1_q       <= hit_d1_d;
      hit_d2_q       <= hit_d2_d;
      pixel_opaque_q <= pixel_opaque_d;
      pixel_rgb_q    <= pixel_rgb_d;
    end
  end

  assign rom_if.rom_addr = rom_addr_q;
  assign pixel_opaque    = pixel_opaque_q;
  assign pixel_rgb       = pixel_rgb_q;
endmodule
